uart_tx_arbiter: RTL

Round-robin arbiter that shares the system's single UART transmitter among up to eight byte-stream requesters (status reporter, debug echo, payload source, …). Grants are packet-locked: once a requester wins, it keeps the transmitter until it flags its last byte or hits a burst or stall limit. The block sits between the requesters and the UART TX core inside `system`, driving the core's write strobe and watching its busy flag.

---
 rtl/uart_tx_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter among up to eight byte-stream requesters.
// Arbitration is round robin, starting the search one past the last owner.
// A grant is packet-locked. The owner keeps the transmitter until it sends a
// byte flagged last, reaches MAX_BURST bytes, or leaves its lane idle for
// STALL_MAX cycles.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req_valid  [N_REQ]    requester i has a byte on lane i
//   req_data   [8*N_REQ]  byte lanes; lane i is bits [8i+7:8i]
//   req_last   [N_REQ]    lane i byte closes its packet
//   req_ready  [N_REQ]    one-hot accept strobe (combinational)
//   tx_busy    UART TX core is shifting a frame
//   tx_wr      one-cycle write strobe to the UART TX core
//   tx_data    byte presented with tx_wr
//   grant      [N_REQ]    one-hot current owner, 0 when nobody owns the TX
//   busy       a grant is active
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int STALL_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 tx_busy,
    output logic                 tx_wr,
    output logic [7:0]           tx_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    // 8-bit counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0] state_q, state_d;
    logic       own_q, own_d;      // a grant is held
    logic [2:0] g_q, g_d;          // index of the owner
    logic [2:0] last_q, last_d;    // index of the previous owner
    logic [7:0] burst_q, burst_d;
    logic [7:0] stall_q, stall_d;
    logic       tx_wr_q, tx_wr_d;
    logic [7:0] tx_data_q, tx_data_d;

    logic [N_REQ-1:0] grant_vec;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       lane_data;
    logic             xfer;
    logic [7:0]       burst_inc;
    logic [7:0]       stall_inc;
    logic             pick_found;
    logic [2:0]       pick_idx;

    assign grant_vec   = own_q ? N_REQ'(8'b1 << g_q) : '0;
    assign owner_valid = |(req_valid & grant_vec);
    assign owner_last  = |(req_last & grant_vec);
    assign req_ready   = (state_q == S_LOAD && !tx_busy) ? (req_valid & grant_vec) : '0;
    assign xfer        = |req_ready;
    assign burst_inc   = sat_inc(burst_q);
    assign stall_inc   = sat_inc(stall_q);

    // Owner lane mux.
    always_comb begin
        lane_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (g_q == 3'(i)) lane_data = req_data[8*i +: 8];
        end
    end

    // Round-robin pick: lowest valid lane above last_q, else lowest valid lane
    // overall (the wrap). Descending loops leave the lowest match in pick_idx.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) > last_q)) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
            end
        end
        if (!pick_found) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        g_d       = g_q;
        last_d    = last_q;
        burst_d   = burst_q;
        stall_d   = stall_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    own_d   = 1'b1;
                    g_d     = pick_idx;
                    burst_d = 8'd0;
                    stall_d = 8'd0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = lane_data;
                    burst_d   = burst_inc;
                    stall_d   = 8'd0;
                    // last and burst limit together still release only once
                    if (owner_last || burst_inc >= BURST_LIM) begin
                        last_d = g_q;
                        own_d  = 1'b0;
                    end
                    state_d = S_GUARD;
                end else if (!tx_busy && !owner_valid) begin
                    // stall counter only runs while the TX core is free
                    stall_d = stall_inc;
                    if (stall_inc >= STALL_LIM) begin
                        last_d  = g_q;
                        own_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            S_GUARD: begin
                // Gives the TX core a cycle to raise tx_busy. After a release
                // this cycle already arbitrates, so the next owner is granted
                // two cycles after the releasing transfer.
                if (own_q) begin
                    state_d = S_LOAD;
                end else if (pick_found) begin
                    own_d   = 1'b1;
                    g_d     = pick_idx;
                    burst_d = 8'd0;
                    stall_d = 8'd0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            own_q     <= 1'b0;
            g_q       <= 3'd0;
            last_q    <= 3'(N_REQ - 1);
            burst_q   <= 8'd0;
            stall_q   <= 8'd0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            g_q       <= g_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            stall_q   <= stall_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
    assign grant   = grant_vec;
    assign busy    = own_q;

endmodule
